// File: rtl/pps_if.sv
// Signal bundle between the PPS conditioner and its environment.
// The master drives the raw pulse and the slave returns the conditioned outputs.
interface pps_if #(
    parameter int CNT_W = 28
);
    logic             pps_in;
    logic             pps_tick;
    logic             pps_out;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic [7:0]       err_cnt;

    modport master (
        output pps_in,
        input  pps_tick, pps_out, locked, period, err_cnt
    );

    modport slave (
        input  pps_in,
        output pps_tick, pps_out, locked, period, err_cnt
    );
endinterface

// File: rtl/pps_conditioner.sv
// Synchronises and validates a raw PPS input, then regenerates a clean tick and pulse.
// Define PPS_HOLDOVER_EN to free-run for up to HOLD_MAX synthesized seconds after losing lock.
module pps_conditioner #(
    parameter int CLK_HZ   = 125000000,
    parameter int TOL      = 1000,
    parameter int PULSE_W  = 1250,
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 28
) (
    input  logic  CLK,
    input  logic  RST,
    pps_if.slave  bus
);
    localparam logic [CNT_W-1:0] LO_C = CNT_W'(CLK_HZ - TOL);
    localparam logic [CNT_W-1:0] HI_C = CNT_W'(CLK_HZ + TOL);
    localparam logic [CNT_W-1:0] TO_C = CNT_W'(CLK_HZ + TOL + 1);
    localparam logic [CNT_W-1:0] PW_C = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    if (CNT_W < 2 || (64'(1) << CNT_W) <= 64'(CLK_HZ + TOL + 1) ||
        PULSE_W < 1 || PULSE_W > CLK_HZ - TOL - 1 || HOLD_MAX < 1) begin : g_bad_params
        $error("pps_conditioner: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
`ifdef PPS_HOLDOVER_EN
        LOCKED,
        HOLDOVER
`else
        LOCKED
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic [7:0]       err_q, err_d;
    logic             tick_q, tick_d;
    logic             out_q, out_d;
    logic             locked_q, locked_d;
    logic             edgeDet, valid, timeout, errInc;
`ifdef PPS_HOLDOVER_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_MAX);
    logic [HW-1:0]    hold_q, hold_d;
`endif

    assign edgeDet = s2_q & ~s3_q;
    assign valid   = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    assign timeout = (cnt_q == TO_C);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;
        period_d = period_q;
        err_d    = err_q;
        tick_d   = 1'b0;
        errInc   = 1'b0;
`ifdef PPS_HOLDOVER_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (edgeDet) begin
                    state_d = ACQ;
                    cnt_d   = ONE_C;
                end
            end
            ACQ: begin
                if (edgeDet) begin
                    cnt_d = ONE_C;
                    if (valid) begin
                        state_d  = LOCKED;
                        period_d = cnt_q;
                        tick_d   = 1'b1;
                    end else begin
                        errInc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                // A timeout swallows an edge landing in the same cycle.
                if (timeout) begin
                    errInc = 1'b1;
`ifdef PPS_HOLDOVER_EN
                    state_d = HOLDOVER;
                    tick_d  = 1'b1;
                    hold_d  = HW'(1);
                    cnt_d   = ONE_C;
`else
                    state_d = IDLE;
`endif
                end else if (edgeDet) begin
                    if (valid) begin
                        tick_d   = 1'b1;
                        period_d = cnt_q;
                        cnt_d    = ONE_C;
                    end else if (cnt_q < LO_C) begin
                        errInc = 1'b1;
                    end
                end
            end
`ifdef PPS_HOLDOVER_EN
            HOLDOVER: begin
                if (edgeDet) begin
                    state_d = ACQ;
                    cnt_d   = ONE_C;
                end else if (cnt_q == period_q) begin
                    if (hold_q < HOLD_C) begin
                        tick_d = 1'b1;
                        hold_d = hold_q + HW'(1);
                        cnt_d  = ONE_C;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (errInc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end

        // pw_q holds the cycles left in the pulse including the current one.
        if (tick_d) begin
            pw_d = PW_C;
        end else if (pw_q != '0) begin
            pw_d = pw_q - ONE_C;
        end else begin
            pw_d = pw_q;
        end
        out_d    = tick_d | (pw_q > ONE_C);
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            pw_q     <= '0;
            err_q    <= '0;
            tick_q   <= 1'b0;
            out_q    <= 1'b0;
            locked_q <= 1'b0;
`ifdef PPS_HOLDOVER_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= bus.pps_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pw_q     <= pw_d;
            err_q    <= err_d;
            tick_q   <= tick_d;
            out_q    <= out_d;
            locked_q <= locked_d;
`ifdef PPS_HOLDOVER_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign bus.pps_tick = tick_q;
    assign bus.pps_out  = out_q;
    assign bus.locked   = locked_q;
    assign bus.period   = period_q;
    assign bus.err_cnt  = err_q;
endmodule
